uart_mmio: RTL
==============

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, wb_clk_i cycles per serial bit; legal range is 4 or more.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 wb_clk_i  in  1  system clock; all state changes on its rising edge.
REQ-004 wb_rst_n  in  1  asynchronous active-low reset.
REQ-005 access_addr  in  8  CPU data-memory address.
REQ-006 w_data  in  8  CPU store data.
REQ-007 w_en  in  1  store strobe for access_addr, one cycle per store.
REQ-008 r_en  in  1  load strobe for access_addr, one cycle per load.
REQ-009 r_data  out  8  combinational read data for a decoded address, 0 otherwise.
REQ-010 r_hit  out  1  combinational; 1 when access_addr is 252, 254 or 255.
REQ-011 rx  in  1  asynchronous serial input.
REQ-012 tx  out  1  serial output; idles high.
REQ-013 int_req  out  1  registered receive interrupt request.

Function
REQ-014 Address 255 CTRL (R/W) SHALL use these bits: bit0 tx_en, bit1 rx_en, bit2 int_en, bit3 loopback; bits 7:4 read 0.
REQ-015 Address 254 STATUS (R) SHALL use these bits: bit0 busy, bit1 receive_flag, bit2 overrun, bit3 frame_err; bits 7:4 read 0; writes are ignored.
REQ-016 A write to address 253 TXDATA with tx_en=1 and busy=0 SHALL load the shift register; busy=1 and tx=0 (start bit) from the next cycle.
REQ-017 A write to TXDATA while busy=1 or tx_en=0 SHALL be dropped silently.
REQ-018 TX FSM SHALL be IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, each bit CLKS_PER_BIT cycles; busy clears in the cycle after the stop bit ends.
REQ-019 Clearing tx_en mid-frame SHALL let the current frame complete.
REQ-020 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-021 RX FSM SHALL be IDLE->START->DATA->STOP->IDLE; a falling edge in IDLE starts START.
REQ-022 The start bit SHALL be re-sampled at CLKS_PER_BIT/2; if it is high, the FSM returns to IDLE with no flags set.
REQ-023 Data and stop bits SHALL be sampled at bit centres.
REQ-024 A valid stop bit (1) SHALL latch RXDATA (address 252, R) and set receive_flag; if receive_flag was already 1, it SHALL also set overrun, and the new byte SHALL overwrite the old one.
REQ-025 A stop bit of 0 SHALL discard the byte, set frame_err and leave receive_flag unchanged.
REQ-026 r_en with access_addr=252 SHALL clear receive_flag, overrun and frame_err in the next cycle.
REQ-027 If that clear coincides with a new byte completing, the new byte SHALL win: receive_flag=1, overrun=0.
REQ-028 With rx_en=0, RX SHALL be held in IDLE; clearing rx_en mid-frame aborts the frame with no flag change.
REQ-029 int_req SHALL equal receive_flag AND int_en, registered: it rises 1 cycle after receive_flag sets and falls 1 cycle after either term clears.
REQ-030 A write to CTRL SHALL take effect in the next cycle.

Reset
REQ-031 Reset SHALL drive tx=1, busy=0, int_req=0, CTRL=0, RXDATA=0, all flags=0, both FSMs=IDLE and synchronizer flops=1.
REQ-032 Reset mid-frame SHALL abort immediately; tx returns high asynchronously.

Configuration
REQ-033 With UART_MMIO_LOOPBACK_EN defined, CTRL bit3=1 SHALL feed the internal tx line to the RX synchronizer input instead of rx, and the tx pin SHALL be held at 1.
REQ-034 Without UART_MMIO_LOOPBACK_EN, CTRL bit3 SHALL be unimplemented: writes ignored, reads 0.

Structure
REQ-035 The address constants (252-255) and CTRL/STATUS bit indices SHALL live in the shared package jacaranda_pkg.
REQ-036 The receive FSM, synchronizer and bit timer SHALL be one sub-module, uart_rx_core; TX and the registers stay in uart_mmio.

Verification
REQ-037 CLKS_PER_BIT=16, CTRL=0x01, write 0xA5 to 253 -> tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1, stop high; busy=1 for exactly 160 cycles.
REQ-038 Write 0x3C to 253 while busy -> transmitted frame is unchanged and 0x3C never appears on tx.
REQ-039 CTRL=0x06, drive 0x5A on rx -> STATUS=0x02, RXDATA=0x5A, int_req=1; r_en at 252 -> STATUS=0x00 and int_req=0 within 2 cycles.
REQ-040 Send two bytes 0x11 then 0x22 without reading -> RXDATA=0x22, STATUS=0x06.
REQ-041 rx low pulse of 4 cycles -> no flags set; frame with stop bit 0 -> STATUS bit3=1, receive_flag=0.
REQ-042 Define UART_MMIO_LOOPBACK_EN, CTRL=0x0B, write 0xC3 -> RXDATA=0xC3 and tx pin constant 1; assert reset mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/jacaranda_pkg.sv
// Shared register map, bit indices and FSM state type for the memory-mapped UART.
package jacaranda_pkg;

  localparam logic [7:0] ADDR_RXDATA = 8'd252;
  localparam logic [7:0] ADDR_TXDATA = 8'd253;
  localparam logic [7:0] ADDR_STATUS = 8'd254;
  localparam logic [7:0] ADDR_CTRL   = 8'd255;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_INT_EN   = 2;
  localparam int CTRL_LOOPBACK = 3;

  localparam int ST_BUSY      = 0;
  localparam int ST_RX_FLAG   = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: two-flop synchronizer, bit timer and RX FSM; emits one-cycle
// byte_valid / frame_err pulses with the assembled byte.
module uart_rx_core
  import jacaranda_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       rx_en,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] byte_data
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = S_START;
      end
      S_START: begin
        // Half a bit in: a high line means the start edge was a glitch.
        if (cnt_q == BIT_HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d    = S_IDLE;
          byte_valid = sync2_q;
          frame_err  = !sync2_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      state_d    = S_IDLE;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: CTRL/STATUS/RXDATA/TXDATA registers and the TX shifter.
// Optional internal loopback is compiled in with UART_MMIO_LOOPBACK_EN.
module uart_mmio
  import jacaranda_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  input  logic [7:0] access_addr,
  input  logic [7:0] w_data,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] r_data,
  output logic       r_hit,
  input  logic       rx,
  output logic       tx,
  output logic       int_req
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_MMIO_LOOPBACK_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = ~(4'd1 << CTRL_LOOPBACK);
`endif

  logic [3:0]    ctrl_q, ctrl_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_flag_q, rx_flag_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          int_req_q, int_req_d;
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  logic       tx_line, tx_busy, rx_src, rd_clr, tx_write;
  logic       rx_byte_valid, rx_frame_err;
  logic [7:0] rx_byte;
  logic [7:0] status;

  assign tx_busy  = (tx_state_q != S_IDLE);
  assign rd_clr   = r_en && (access_addr == ADDR_RXDATA);
  assign tx_write = w_en && (access_addr == ADDR_TXDATA) && ctrl_q[CTRL_TX_EN] && !tx_busy;

  always_comb begin
    tx_line = 1'b1;
    if (tx_state_q == S_START) tx_line = 1'b0;
    else if (tx_state_q == S_DATA) tx_line = tx_shift_q[0];
  end

`ifdef UART_MMIO_LOOPBACK_EN
  assign tx     = ctrl_q[CTRL_LOOPBACK] ? 1'b1 : tx_line;
  assign rx_src = ctrl_q[CTRL_LOOPBACK] ? tx_line : rx;
`else
  assign tx     = tx_line;
  assign rx_src = rx;
`endif

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n),
    .rx_in      (rx_src),
    .rx_en      (ctrl_q[CTRL_RX_EN]),
    .byte_valid (rx_byte_valid),
    .frame_err  (rx_frame_err),
    .byte_data  (rx_byte)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ctrl_q      <= '0;
      rx_data_q   <= '0;
      rx_flag_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      int_req_q   <= 1'b0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      rx_data_q   <= rx_data_d;
      rx_flag_q   <= rx_flag_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      int_req_q   <= int_req_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
    end
  end

  // Register file and receive flags; a completing byte overrides a read-clear.
  always_comb begin
    ctrl_d      = ctrl_q;
    rx_data_d   = rx_data_q;
    rx_flag_d   = rx_flag_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (w_en && (access_addr == ADDR_CTRL)) ctrl_d = w_data[3:0] & CTRL_MASK;
    if (rd_clr) begin
      rx_flag_d   = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rx_byte_valid) begin
      rx_data_d = rx_byte;
      rx_flag_d = 1'b1;
      if (rx_flag_q && !rd_clr) overrun_d = 1'b1;
    end
    if (rx_frame_err) frame_err_d = 1'b1;
    int_req_d = rx_flag_q && ctrl_q[CTRL_INT_EN];
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (tx_write) begin
          tx_shift_d = w_data;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = tx_busy;
    status[ST_RX_FLAG]   = rx_flag_q;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    case (access_addr)
      ADDR_RXDATA: r_data = rx_data_q;
      ADDR_STATUS: r_data = status;
      ADDR_CTRL:   r_data = {4'b0000, ctrl_q};
      default:     r_data = '0;
    endcase
  end

  assign r_hit   = (access_addr == ADDR_RXDATA) || (access_addr == ADDR_STATUS) ||
                   (access_addr == ADDR_CTRL);
  assign int_req = int_req_q;

endmodule
